// File: rtl/nv_ram_rwsthp_fifo_ctl.sv
// nv_ram_rwsthp_fifo_ctl
// Valid/ready FIFO controller for an external 2-port RAM with registered
// read address and registered output (nv_ram_rwsthp_DxW family). Reading is
// a two-stage pipeline: stage A is the address held in the RAM, and stage B
// is the RAM output register, which also serves as the FIFO output register.
// Optional feature macro: NV_RAM_RWSTHP_FIFO_BYPASS_EN. When it is defined,
// a write into a completely empty pipeline goes straight into the RAM output
// register through the RAM bypass path.
module nv_ram_rwsthp_fifo_ctl #(
    parameter int DEPTH = 60,
    parameter int WIDTH = 84,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [5:0]       count,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_re,
    output logic             ram_ore,
    output logic             ram_byp_sel,
    output logic [WIDTH-1:0] ram_dbyp,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic [31:0]      ram_pwrbus_ram_pd
);

    localparam logic [6:0]    DEPTH_C = 7'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [6:0]    r_ram_cnt;
    logic [5:0]    r_count;
    logic          r_a_vld;
    logic          r_b_vld;

    logic          w_wr_prdy;
    logic          w_wr_acc;
    logic          w_byp;
    logic          w_we;
    logic          w_re;
    logic          w_ore;
    logic          w_pop;
    logic [6:0]    w_unread;
    logic [6:0]    w_ram_cnt_nxt;
    logic          w_b_vld_nxt;

    // Write side: accept while the RAM (including the stage-A slot) has room.
    assign w_wr_prdy = !rst && (r_ram_cnt != DEPTH_C);
    assign w_wr_acc  = wr_pvld && w_wr_prdy;

`ifdef NV_RAM_RWSTHP_FIFO_BYPASS_EN
    // Bypass only when nothing older sits in the RAM or stage A and the
    // output register is either empty or being popped this cycle.
    assign w_byp    = w_wr_acc && (r_ram_cnt == 7'd0) && !(r_b_vld && !rd_prdy);
    assign ram_dbyp = wr_pd;
`else
    assign w_byp    = 1'b0;
    assign ram_dbyp = '0;
`endif

    // Read pipeline control: stage B loads from stage A (or the bypass), and
    // stage A refills whenever it is empty or moving forward.
    assign w_unread = r_ram_cnt - {6'd0, r_a_vld};
    assign w_ore    = !rst && ((r_a_vld && (!r_b_vld || rd_prdy)) || w_byp);
    assign w_re     = !rst && (w_unread != 7'd0) && (!r_a_vld || w_ore);
    assign w_we     = w_wr_acc && !w_byp;
    assign w_pop    = r_b_vld && rd_prdy;

    assign w_ram_cnt_nxt = r_ram_cnt + {6'd0, w_we} - {6'd0, (w_ore && !w_byp)};
    assign w_b_vld_nxt   = w_ore ? 1'b1 : (w_pop ? 1'b0 : r_b_vld);

    // Write and read pointers, each wrapping at DEPTH-1 for non-power-of-2 depths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_re) begin
                r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Stage valid flags; a new capture into stage A wins over its departure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_vld <= 1'b0;
            r_b_vld <= 1'b0;
        end else begin
            if (w_re) begin
                r_a_vld <= 1'b1;
            end else if (w_ore) begin
                r_a_vld <= 1'b0;
            end
            r_b_vld <= w_b_vld_nxt;
        end
    end

    // Occupancy: RAM-side count plus a registered total including stage B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_cnt <= '0;
            r_count   <= '0;
        end else begin
            r_ram_cnt <= w_ram_cnt_nxt;
            r_count   <= w_ram_cnt_nxt[5:0] + {5'd0, w_b_vld_nxt};
        end
    end

    assign wr_prdy           = w_wr_prdy;
    assign rd_pvld           = r_b_vld;
    assign rd_pd             = ram_dout;
    assign count             = r_count;
    assign ram_wa            = r_wr_ptr;
    assign ram_we            = w_we;
    assign ram_di            = wr_pd;
    assign ram_ra            = r_rd_ptr;
    assign ram_re            = w_re;
    assign ram_ore           = w_ore;
    assign ram_byp_sel       = w_byp;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_rwsthp_fifo_ctl.sv
// Testbench for nv_ram_rwsthp_fifo_ctl with a behavioural model of the
// registered-address, registered-output RAM beside it.
`timescale 1ns/1ps
module tb_nv_ram_rwsthp_fifo_ctl;

   localparam int DEPTH = 60;
   localparam int WIDTH = 84;
   localparam int AW    = 6;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             wrPvld = 1'b0;
   logic             wrPrdy;
   logic [WIDTH-1:0] wrPd = '0;
   logic             rdPvld;
   logic             rdPrdy = 1'b0;
   logic [WIDTH-1:0] rdPd;
   logic [5:0]       fifoCount;
   logic [AW-1:0]    ramWa;
   logic             ramWe;
   logic [WIDTH-1:0] ramDi;
   logic [AW-1:0]    ramRa;
   logic             ramRe;
   logic             ramOre;
   logic             ramBypSel;
   logic [WIDTH-1:0] ramDbyp;
   logic [WIDTH-1:0] ramDout = '0;
   logic [31:0]      pwrIn = 32'hCAFE_0123;
   logic [31:0]      pwrOut;

   logic [WIDTH-1:0] ramMem [0:DEPTH-1];
   logic [AW-1:0]    ramRaReg = '0;

   int testsRun = 0;
   int testsFailed = 0;

   logic [WIDTH-1:0] expQ [$];
   logic [AW-1:0]    waLog [$];
   logic [AW-1:0]    raLog [$];
   bit               sbOn = 1'b0;
   bit               prevHold = 1'b0;
   logic [WIDTH-1:0] prevPd = '0;
   int               acceptCount = 0;
   int               popCount = 0;
   int               cycleNo = 0;
   int               firstPopCycle = 0;
   int               lastPopCycle = 0;

   typedef struct {
      logic             wrVld;
      logic [WIDTH-1:0] wrData;
      logic             rdRdy;
      logic             expWe;
      logic [AW-1:0]    expWa;
      logic             expRe;
      logic [AW-1:0]    expRa;
      logic             expOre;
      logic             expRdVld;
      logic [WIDTH-1:0] expRdPd;
      logic [5:0]       expCount;
   } vecT;

   vecT vecs [12];

   // Free-running core clock, 10 ns period.
   always #5 clock = ~clock;

   nv_ram_rwsthp_fifo_ctl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clock),
      .rst(reset),
      .wr_pvld(wrPvld),
      .wr_prdy(wrPrdy),
      .wr_pd(wrPd),
      .rd_pvld(rdPvld),
      .rd_prdy(rdPrdy),
      .rd_pd(rdPd),
      .count(fifoCount),
      .ram_wa(ramWa),
      .ram_we(ramWe),
      .ram_di(ramDi),
      .ram_ra(ramRa),
      .ram_re(ramRe),
      .ram_ore(ramOre),
      .ram_byp_sel(ramBypSel),
      .ram_dbyp(ramDbyp),
      .ram_dout(ramDout),
      .pwrbus_ram_pd(pwrIn),
      .ram_pwrbus_ram_pd(pwrOut)
   );

   // RAM model: write port, registered read address, registered output with bypass mux.
   always @(posedge clock) begin
      if (ramWe) ramMem[ramWa] <= ramDi;
      if (ramRe) ramRaReg <= ramRa;
      if (ramOre) ramDout <= ramBypSel ? ramDbyp : ramMem[ramRaReg];
   end

   // Safety net so the run always ends on its own.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One clock cycle: sample just before the rising edge, then return at the falling edge.
   task automatic stepCycle();
      #4;
      if (sbOn) begin
         if (prevHold) begin
            checkOutput("holdVld", rdPvld, 1);
            checkOutput("holdPd", rdPd, prevPd);
         end
         if (wrPvld && wrPrdy) begin
            expQ.push_back(wrPd);
            waLog.push_back(ramWa);
            acceptCount++;
         end
         if (ramRe) raLog.push_back(ramRa);
         if (rdPvld && rdPrdy) begin
            if (expQ.size() == 0) checkOutput("popUnderflow", 1, 0);
            else checkOutput("popData", rdPd, expQ.pop_front());
            if (popCount == 0) firstPopCycle = cycleNo;
            lastPopCycle = cycleNo;
            popCount++;
         end
         prevHold = rdPvld && !rdPrdy;
         prevPd   = rdPd;
`ifndef NV_RAM_RWSTHP_FIFO_BYPASS_EN
         checkOutput("bypSelOff", ramBypSel, 0);
         checkOutput("dbypZero", ramDbyp, 0);
`endif
      end
      @(posedge clock);
      @(negedge clock);
      cycleNo++;
   endtask

   task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] data, input logic rdy);
      wrPvld = vld;
      wrPd   = data;
      rdPrdy = rdy;
   endtask

   task automatic doReset();
      applyStimulus(0, '0, 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      expQ.delete();
      waLog.delete();
      raLog.delete();
      prevHold = 1'b0;
      acceptCount = 0;
      popCount = 0;
   endtask

   initial begin
      // Test 1: reset values and release.
      #2;
      checkOutput("rstWrPrdy", wrPrdy, 0);
      checkOutput("rstRdPvld", rdPvld, 0);
      checkOutput("rstCount", fifoCount, 0);
      checkOutput("pwrbus", pwrOut, pwrIn);
      @(negedge clock);
      reset = 1'b0;
      #4;
      checkOutput("relWrPrdy", wrPrdy, 1);
      @(negedge clock);

      // Mid-stream reset: load five entries, then reset between clock edges.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, WIDTH'(i + 16), 0);
         stepCycle();
      end
      applyStimulus(0, '0, 0);
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("preRstCount", fifoCount, 5);
      checkOutput("preRstVld", rdPvld, 1);
      applyStimulus(1, 84'h77, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midRstVld", rdPvld, 0);
      checkOutput("midRstCount", fifoCount, 0);
      checkOutput("midRstWe", ramWe, 0);
      checkOutput("midRstOre", ramOre, 0);
      checkOutput("midRstRe", ramRe, 0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(0, '0, 0);

`ifndef NV_RAM_RWSTHP_FIFO_BYPASS_EN
      // Test 2: cycle-by-cycle table, single-entry latency then a backpressured pair.
      vecs[0]  = '{1'b1, 84'hA5, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 84'h0,  6'd0};
      vecs[1]  = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 1'b0, 84'h0,  6'd1};
      vecs[2]  = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 84'h0,  6'd1};
      vecs[3]  = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 84'hA5, 6'd1};
      vecs[4]  = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 84'h0,  6'd0};
      vecs[5]  = '{1'b1, 84'hB1, 1'b0, 1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 1'b0, 84'h0,  6'd0};
      vecs[6]  = '{1'b1, 84'hB2, 1'b0, 1'b1, 6'd2, 1'b1, 6'd1, 1'b0, 1'b0, 84'h0,  6'd1};
      vecs[7]  = '{1'b0, 84'h0,  1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b1, 1'b0, 84'h0,  6'd2};
      vecs[8]  = '{1'b0, 84'h0,  1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 84'hB1, 6'd2};
      vecs[9]  = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 84'hB1, 6'd2};
      vecs[10] = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 84'hB2, 6'd1};
      vecs[11] = '{1'b0, 84'h0,  1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 84'h0,  6'd0};
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].wrVld, vecs[i].wrData, vecs[i].rdRdy);
         #4;
         checkOutput($sformatf("v%0d.we", i), ramWe, vecs[i].expWe);
         if (vecs[i].expWe) checkOutput($sformatf("v%0d.wa", i), ramWa, vecs[i].expWa);
         checkOutput($sformatf("v%0d.re", i), ramRe, vecs[i].expRe);
         if (vecs[i].expRe) checkOutput($sformatf("v%0d.ra", i), ramRa, vecs[i].expRa);
         checkOutput($sformatf("v%0d.ore", i), ramOre, vecs[i].expOre);
         checkOutput($sformatf("v%0d.vld", i), rdPvld, vecs[i].expRdVld);
         if (vecs[i].expRdVld) checkOutput($sformatf("v%0d.pd", i), rdPd, vecs[i].expRdPd);
         checkOutput($sformatf("v%0d.count", i), fifoCount, vecs[i].expCount);
         @(posedge clock);
         @(negedge clock);
      end
`endif

      // Test 3: fill under full backpressure, then drain in order.
      doReset();
      sbOn = 1'b1;
      for (int i = 0; i < 80; i++) begin
         applyStimulus(acceptCount <= 70, WIDTH'(acceptCount), 0);
         stepCycle();
      end
      applyStimulus(0, '0, 0);
      checkOutput("fullAccepted", WIDTH'(acceptCount), 61);
      checkOutput("fullWrPrdy", wrPrdy, 0);
      checkOutput("fullCount", fifoCount, 61);
      rdPrdy = 1'b1;
      for (int i = 0; i < 200 && popCount < 61; i++) stepCycle();
      checkOutput("drainPops", WIDTH'(popCount), 61);
      checkOutput("drainSpan", WIDTH'(lastPopCycle - firstPopCycle), 60);
      stepCycle();
      checkOutput("drainCount", fifoCount, 0);

      // Test 4: continuous stream across the pointer wrap.
      doReset();
      for (int i = 0; i < 400 && popCount < 150; i++) begin
         applyStimulus(acceptCount < 150, WIDTH'(acceptCount), 1);
         stepCycle();
      end
      checkOutput("streamPops", WIDTH'(popCount), 150);
      checkOutput("streamSpan", WIDTH'(lastPopCycle - firstPopCycle), 149);
`ifndef NV_RAM_RWSTHP_FIFO_BYPASS_EN
      if (waLog.size() >= 62 && raLog.size() >= 62) begin
         checkOutput("wa58", waLog[58], 58);
         checkOutput("wa59", waLog[59], 59);
         checkOutput("wa60", waLog[60], 0);
         checkOutput("wa61", waLog[61], 1);
         checkOutput("ra59", raLog[59], 59);
         checkOutput("ra60", raLog[60], 0);
      end else begin
         checkOutput("ptrLogSize", WIDTH'(raLog.size()), 62);
      end
`endif

      // Test 5: random valid/ready traffic against the scoreboard.
      doReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
         stepCycle();
      end
      applyStimulus(0, '0, 1);
      for (int i = 0; i < 200 && expQ.size() != 0; i++) stepCycle();
      stepCycle();
      checkOutput("randEmpty", WIDTH'(expQ.size()), 0);
      checkOutput("randCount", fifoCount, 0);

`ifdef NV_RAM_RWSTHP_FIFO_BYPASS_EN
      // Test 6: bypass into an empty pipeline, then the normal path when data is pending.
      doReset();
      sbOn = 1'b0;
      applyStimulus(1, 84'h3C, 1);
      #4;
      checkOutput("bypWe", ramWe, 0);
      checkOutput("bypSel", ramBypSel, 1);
      checkOutput("bypOre", ramOre, 1);
      checkOutput("bypDbyp", ramDbyp, 84'h3C);
      @(posedge clock);
      @(negedge clock);
      applyStimulus(1, 84'h41, 0);
      #4;
      checkOutput("bypVld", rdPvld, 1);
      checkOutput("bypPd", rdPd, 84'h3C);
      checkOutput("bypCount", fifoCount, 1);
      checkOutput("heldWe", ramWe, 1);
      checkOutput("heldSel", ramBypSel, 0);
      @(posedge clock);
      @(negedge clock);
      applyStimulus(1, 84'h42, 1);
      #4;
      checkOutput("pendWe", ramWe, 1);
      checkOutput("pendSel", ramBypSel, 0);
      @(posedge clock);
      @(negedge clock);
      applyStimulus(0, '0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
